// File: rtl/dcache_meta_pkg.sv
// Shared types and helpers for the D-cache metadata array.
// Entry packing helpers do not depend on DCACHE_META_PARITY_EN; callers pass the enable in.
package dcache_meta_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } meta_state_e;

    localparam int PAR_MAX_WIDTH = 64;

    function automatic logic even_par(input logic [PAR_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

    function automatic int entry_bits(input int width, input bit par_en);
        return width + (par_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/dcache_meta_array_way.sv
// One way of the metadata array: storage, a single write port and two bypassed read ports.
// Optional parity storage/check under DCACHE_META_PARITY_EN.
module dcache_meta_way
    import dcache_meta_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_idx,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               byp_en,
    input  logic [S_INDEX-1:0] byp_idx,
    input  logic [WIDTH-1:0]   byp_data,
    input  logic [S_INDEX-1:0] rindex0,
    input  logic [S_INDEX-1:0] rindex1,
    output logic [WIDTH-1:0]   rdata0,
    output logic [WIDTH-1:0]   rdata1,
    output logic               perr0,
    output logic               perr1
);

`ifdef DCACHE_META_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int EW       = entry_bits(WIDTH, PAR_EN);

    logic [EW-1:0] mem [NUM_SETS];
    logic [EW-1:0] wr_entry;
    logic          hit0;
    logic          hit1;

`ifdef DCACHE_META_PARITY_EN
    assign wr_entry = {even_par(PAR_MAX_WIDTH'(wr_data)), wr_data};
`else
    assign wr_entry = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign hit0   = byp_en && (rindex0 == byp_idx);
    assign hit1   = byp_en && (rindex1 == byp_idx);
    assign rdata0 = hit0 ? byp_data : mem[rindex0][WIDTH-1:0];
    assign rdata1 = hit1 ? byp_data : mem[rindex1][WIDTH-1:0];

`ifdef DCACHE_META_PARITY_EN
    // A bypassed way shows fresh write data, so its stale stored parity is irrelevant.
    assign perr0 = !hit0 &&
                   (mem[rindex0][WIDTH] != even_par(PAR_MAX_WIDTH'(mem[rindex0][WIDTH-1:0])));
    assign perr1 = !hit1 &&
                   (mem[rindex1][WIDTH] != even_par(PAR_MAX_WIDTH'(mem[rindex1][WIDTH-1:0])));
`else
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
`endif

endmodule

// File: rtl/dcache_meta_array.sv
// D-cache metadata array: N_WAYS way instances plus the clear sweep FSM.
// Define DCACHE_META_PARITY_EN to store and check per-entry even parity.
module dcache_meta_array
    import dcache_meta_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int N_WAYS  = 2,
    parameter int WIDTH   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_req,
    output logic                      busy,
    input  logic                      load,
    input  logic [N_WAYS-1:0]         wmask,
    input  logic [S_INDEX-1:0]        windex,
    input  logic [N_WAYS*WIDTH-1:0]   datain,
    input  logic [S_INDEX-1:0]        rindex0,
    input  logic [S_INDEX-1:0]        rindex1,
    output logic [N_WAYS*WIDTH-1:0]   dataout0,
    output logic [N_WAYS*WIDTH-1:0]   dataout1,
    output logic                      perr0,
    output logic                      perr1
);

    localparam int                 NUM_SETS = 2 ** S_INDEX;
    localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

    meta_state_e        state;
    meta_state_e        state_next;
    logic [S_INDEX-1:0] clr_idx;
    logic [S_INDEX-1:0] clr_idx_next;

    logic [N_WAYS*WIDTH-1:0] way_rd0;
    logic [N_WAYS*WIDTH-1:0] way_rd1;
    logic [N_WAYS-1:0]       way_perr0;
    logic [N_WAYS-1:0]       way_perr1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // The sweep leaves CLEAR after writing the last set, so clr_idx never runs past it.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_next = clr_idx + S_INDEX'(1);
                if (clr_idx == LAST_SET) begin
                    state_next   = READY;
                    clr_idx_next = '0;
                end
            end
            READY: begin
                if (flush_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        logic wr_en;
        assign wr_en = busy || (load && wmask[w]);

        dcache_meta_way #(
            .S_INDEX (S_INDEX),
            .WIDTH   (WIDTH)
        ) u_way (
            .clk      (clk),
            .wr_en    (wr_en),
            .wr_idx   (busy ? clr_idx : windex),
            .wr_data  (busy ? '0 : datain[w*WIDTH +: WIDTH]),
            .byp_en   (load && wmask[w]),
            .byp_idx  (windex),
            .byp_data (datain[w*WIDTH +: WIDTH]),
            .rindex0  (rindex0),
            .rindex1  (rindex1),
            .rdata0   (way_rd0[w*WIDTH +: WIDTH]),
            .rdata1   (way_rd1[w*WIDTH +: WIDTH]),
            .perr0    (way_perr0[w]),
            .perr1    (way_perr1[w])
        );
    end

    // Contents are meaningless mid-sweep, so reads are masked to zero while busy.
    assign dataout0 = busy ? '0 : way_rd0;
    assign dataout1 = busy ? '0 : way_rd1;
    assign perr0    = !busy && (|way_perr0);
    assign perr1    = !busy && (|way_perr1);

endmodule
